// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, funct codes and the arbiter FSM encoding.
package alu_pkg;
    localparam int WORD_SIZE = 16;
    localparam int FUNCT_W   = 4;

    localparam logic [FUNCT_W-1:0] FUNCT_AND = 4'b0000;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 4'b0001;
    localparam logic [FUNCT_W-1:0] FUNCT_XOR = 4'b0010;
    localparam logic [FUNCT_W-1:0] FUNCT_NOT = 4'b0011;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'b0100;
    localparam logic [FUNCT_W-1:0] FUNCT_MUL = 4'b0101;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 4'b0110;
    localparam logic [FUNCT_W-1:0] FUNCT_NOP = 4'b0111;
    localparam logic [FUNCT_W-1:0] FUNCT_SHL = 4'b1000;
    localparam logic [FUNCT_W-1:0] FUNCT_SHR = 4'b1001;
    localparam logic [FUNCT_W-1:0] FUNCT_EQZ = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_t;

    // Only the arithmetic functs refresh the ALU's overflow flag; for the rest it is stale.
    function automatic logic funct_sets_ovf(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_ADD) || (f == FUNCT_MUL) || (f == FUNCT_SUB);
    endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's op request channel plus its result return channel.
interface alu_share_arbiter_if #(
    parameter int WORD_SIZE = alu_pkg::WORD_SIZE,
    parameter int FUNCT_W   = alu_pkg::FUNCT_W
);
    logic                 valid;
    logic                 ready;
    logic [FUNCT_W-1:0]   funct;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic [WORD_SIZE-1:0] imm;
    logic                 alusrc;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_result;
    logic                 rsp_zero;
    logic                 rsp_overflow;

    modport master (
        output valid, funct, a, b, imm, alusrc, rsp_ready,
        input  ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow
    );

    modport slave (
        input  valid, funct, a, b, imm, alusrc, rsp_ready,
        output ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way request picker. Round-robin by default; ALU_ARB_FIXED_PRIO_EN gives req1 fixed priority.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_en,
    output logic o_gnt0,
    output logic o_gnt1
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    assign o_gnt1 = i_en & i_req1;
    assign o_gnt0 = i_en & i_req0 & ~i_req1;
`else
    logic r_rr_last;

    // On a tie the requester that did not win last time is granted.
    assign o_gnt0 = i_en & i_req0 & (~i_req1 | r_rr_last);
    assign o_gnt1 = i_en & i_req1 & (~i_req0 | ~r_rr_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (o_gnt0 | o_gnt1) begin
            r_rr_last <= o_gnt1;
        end
    end
`endif
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one registered ALU between two requesters: arbitrate, issue one cycle, capture, respond.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: req1 always wins ties instead of round-robin.
module alu_share_arbiter #(
    parameter int WORD_SIZE = alu_pkg::WORD_SIZE,
    parameter int FUNCT_W   = alu_pkg::FUNCT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   req0,
    alu_share_arbiter_if.slave   req1,
    output logic                 o_alu_en,
    output logic [FUNCT_W-1:0]   o_alu_funct,
    output logic [WORD_SIZE-1:0] o_alu_in1,
    output logic [WORD_SIZE-1:0] o_alu_reg_in2,
    output logic [WORD_SIZE-1:0] o_alu_imm_in2,
    output logic                 o_alu_alusrc,
    input  logic [WORD_SIZE-1:0] i_alu_result,
    input  logic                 i_alu_overflow
);
    import alu_pkg::*;

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic                 r_owner;
    logic [FUNCT_W-1:0]   r_funct;
    logic [WORD_SIZE-1:0] r_a;
    logic [WORD_SIZE-1:0] r_b;
    logic [WORD_SIZE-1:0] r_imm;
    logic                 r_alusrc;
    logic [WORD_SIZE-1:0] r_result;
    logic                 r_zero;
    logic                 r_ovf;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_accept;
    logic                 w_rsp_hs;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req0 (req0.valid),
        .i_req1 (req1.valid),
        .i_en   (r_state == ST_IDLE),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    assign w_accept = w_gnt0 | w_gnt1;
    assign w_rsp_hs = (r_state == ST_RESP) && (r_owner ? req1.rsp_ready : req0.rsp_ready);

    assign req0.ready        = w_gnt0;
    assign req1.ready        = w_gnt1;
    assign req0.rsp_valid    = (r_state == ST_RESP) && !r_owner;
    assign req1.rsp_valid    = (r_state == ST_RESP) && r_owner;
    assign req0.rsp_result   = r_result;
    assign req1.rsp_result   = r_result;
    assign req0.rsp_zero     = r_zero;
    assign req1.rsp_zero     = r_zero;
    assign req0.rsp_overflow = r_ovf;
    assign req1.rsp_overflow = r_ovf;

    // Operands stay parked on the ALU inputs; alu_en alone qualifies them.
    assign o_alu_funct   = r_funct;
    assign o_alu_in1     = r_a;
    assign o_alu_reg_in2 = r_b;
    assign o_alu_imm_in2 = r_imm;
    assign o_alu_alusrc  = r_alusrc;

    always_comb begin
        w_state_nxt = r_state;
        o_alu_en    = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                o_alu_en    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT:  w_state_nxt = ST_RESP;
            ST_RESP:  if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_funct  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_alusrc <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner  <= w_gnt1;
                r_funct  <= w_gnt1 ? req1.funct  : req0.funct;
                r_a      <= w_gnt1 ? req1.a      : req0.a;
                r_b      <= w_gnt1 ? req1.b      : req0.b;
                r_imm    <= w_gnt1 ? req1.imm    : req0.imm;
                r_alusrc <= w_gnt1 ? req1.alusrc : req0.alusrc;
            end
            // The ALU registered its result at the end of ISSUE, so it is valid here.
            if (r_state == ST_WAIT) begin
                r_result <= i_alu_result;
                r_zero   <= (i_alu_result == '0);
                r_ovf    <= funct_sets_ovf(r_funct) & i_alu_overflow;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small registered ALU model behind it.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    typedef struct {
        bit          side;
        logic [3:0]  funct;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        alusrc;
        logic [15:0] res;
        logic        zero;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_en;
    logic [3:0]  alu_funct;
    logic [15:0] alu_in1, alu_reg_in2, alu_imm_in2;
    logic        alu_alusrc;
    logic [15:0] alu_result;
    logic        alu_overflow;
    int          n_cmp = 0;
    int          n_err = 0;

    alu_share_arbiter_if r0_if ();
    alu_share_arbiter_if r1_if ();

    alu_share_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req0           (r0_if),
        .req1           (r1_if),
        .o_alu_en       (alu_en),
        .o_alu_funct    (alu_funct),
        .o_alu_in1      (alu_in1),
        .o_alu_reg_in2  (alu_reg_in2),
        .o_alu_imm_in2  (alu_imm_in2),
        .o_alu_alusrc   (alu_alusrc),
        .i_alu_result   (alu_result),
        .i_alu_overflow (alu_overflow)
    );

    always #5 clk = ~clk;

    // Registered ALU model: NOP/undefined hold the result, non-arithmetic functs leave overflow stale.
    logic [15:0]        m_in2, m_res_nxt;
    logic               m_ovf_nxt, m_upd_ovf, m_upd_res;
    logic signed [31:0] m_prod;
    always_comb begin
        m_in2     = alu_alusrc ? alu_imm_in2 : alu_reg_in2;
        m_res_nxt = alu_result;
        m_ovf_nxt = alu_overflow;
        m_upd_ovf = 1'b0;
        m_upd_res = 1'b1;
        m_prod    = $signed(alu_in1) * $signed(m_in2);
        case (alu_funct)
            FUNCT_AND: m_res_nxt = alu_in1 & m_in2;
            FUNCT_OR:  m_res_nxt = alu_in1 | m_in2;
            FUNCT_XOR: m_res_nxt = alu_in1 ^ m_in2;
            FUNCT_NOT: m_res_nxt = ~alu_in1;
            FUNCT_ADD: begin
                m_res_nxt = alu_in1 + m_in2;
                m_ovf_nxt = (alu_in1[15] == m_in2[15]) && (m_res_nxt[15] != alu_in1[15]);
                m_upd_ovf = 1'b1;
            end
            FUNCT_MUL: begin
                m_res_nxt = m_prod[15:0];
                m_ovf_nxt = (m_prod != {{16{m_prod[15]}}, m_prod[15:0]});
                m_upd_ovf = 1'b1;
            end
            FUNCT_SUB: begin
                m_res_nxt = alu_in1 - m_in2;
                m_ovf_nxt = (alu_in1[15] != m_in2[15]) && (m_res_nxt[15] != alu_in1[15]);
                m_upd_ovf = 1'b1;
            end
            FUNCT_SHL: m_res_nxt = alu_in1 << m_in2[3:0];
            FUNCT_SHR: m_res_nxt = alu_in1 >> m_in2[3:0];
            FUNCT_EQZ: m_res_nxt = {15'd0, (alu_in1 == 16'd0)};
            default:   m_upd_res = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result   <= 16'd0;
            alu_overflow <= 1'b0;
        end else if (alu_en) begin
            if (m_upd_res) alu_result <= m_res_nxt;
            if (m_upd_ovf) alu_overflow <= m_ovf_nxt;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit s, input logic v, input vec_t x);
        if (!s) begin
            r0_if.valid = v; r0_if.funct = x.funct; r0_if.a = x.a;
            r0_if.b = x.b; r0_if.imm = x.imm; r0_if.alusrc = x.alusrc;
        end else begin
            r1_if.valid = v; r1_if.funct = x.funct; r1_if.a = x.a;
            r1_if.b = x.b; r1_if.imm = x.imm; r1_if.alusrc = x.alusrc;
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? r1_if.ready : r0_if.ready;
    endfunction

    function automatic logic rspv(input bit s);
        return s ? r1_if.rsp_valid : r0_if.rsp_valid;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        r0_if.valid = 1'b0;
        r1_if.valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for the requester's ready; returns with the caller just past that negedge.
    task automatic wait_ready(input bit s, input string nm);
        bit got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (rdy(s)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, " accept"}, {31'd0, got}, 32'd1);
    endtask

    task automatic do_op(input vec_t v, input string nm);
        @(negedge clk);
        drive(v.side, 1'b1, v);
        wait_ready(v.side, nm);
        chk({nm, " other ready"}, {31'd0, rdy(!v.side)}, 32'd0);
        @(negedge clk);
        drive(v.side, 1'b0, v);
        #1;
        chk({nm, " issue en"}, {31'd0, alu_en}, 32'd1);
        chk({nm, " issue funct"}, {28'd0, alu_funct}, {28'd0, v.funct});
        chk({nm, " issue in1"}, {16'd0, alu_in1}, {16'd0, v.a});
        chk({nm, " issue in2"}, {alu_reg_in2, alu_imm_in2}, {v.b, v.imm});
        chk({nm, " issue alusrc"}, {31'd0, alu_alusrc}, {31'd0, v.alusrc});
        @(negedge clk);
        #1;
        chk({nm, " wait en"}, {31'd0, alu_en}, 32'd0);
        chk({nm, " wait rsp"}, {31'd0, rspv(v.side)}, 32'd0);
        chk({nm, " wait in1 held"}, {16'd0, alu_in1}, {16'd0, v.a});
        @(negedge clk);
        #1;
        chk({nm, " rsp valid"}, {30'd0, rspv(v.side), rspv(!v.side)}, 32'd2);
        chk({nm, " result"}, {16'd0, r0_if.rsp_result}, {16'd0, v.res});
        chk({nm, " zero"}, {31'd0, r0_if.rsp_zero}, {31'd0, v.zero});
        chk({nm, " overflow"}, {31'd0, r0_if.rsp_overflow}, {31'd0, v.ovf});
        @(negedge clk);
        #1;
        chk({nm, " rsp one cycle"}, {31'd0, rspv(v.side)}, 32'd0);
    endtask

    vec_t tbl[10];
    vec_t s0[2], s1[2];
    vec_t bp0, bp1;
    int   order[4], acc_cyc[4], exp_order[4];
    int   i0, i1, j0, j1, na;
    bit   got;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        r0_if.valid = 1'b0; r0_if.funct = '0; r0_if.a = '0; r0_if.b = '0;
        r0_if.imm = '0; r0_if.alusrc = 1'b0; r0_if.rsp_ready = 1'b1;
        r1_if.valid = 1'b0; r1_if.funct = '0; r1_if.a = '0; r1_if.b = '0;
        r1_if.imm = '0; r1_if.alusrc = 1'b0; r1_if.rsp_ready = 1'b1;

        tbl[0] = '{1'b0, FUNCT_ADD, 16'h0005, 16'h0003, 16'h0000, 1'b0, 16'h0008, 1'b0, 1'b0};
        tbl[1] = '{1'b1, FUNCT_ADD, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{1'b1, FUNCT_AND, 16'hFFFF, 16'h0F0F, 16'h0000, 1'b0, 16'h0F0F, 1'b0, 1'b0};
        tbl[3] = '{1'b0, FUNCT_SUB, 16'h0007, 16'h0007, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{1'b0, FUNCT_OR,  16'h00F0, 16'hFF00, 16'h000F, 1'b1, 16'h00FF, 1'b0, 1'b0};
        tbl[5] = '{1'b1, FUNCT_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6] = '{1'b0, FUNCT_SUB, 16'h8000, 16'h0001, 16'h0000, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[7] = '{1'b1, FUNCT_XOR, 16'h1234, 16'h0000, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[8] = '{1'b0, FUNCT_NOP, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[9] = '{1'b1, FUNCT_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset ready", {30'd0, r0_if.ready, r1_if.ready}, 32'd0);
        chk("reset rsp valid", {30'd0, r0_if.rsp_valid, r1_if.rsp_valid}, 32'd0);
        chk("reset rsp data", {14'd0, r0_if.rsp_zero, r0_if.rsp_overflow, r0_if.rsp_result}, 32'd0);
        chk("reset alu en", {31'd0, alu_en}, 32'd0);
        chk("reset alu ops", {alu_in1, alu_reg_in2}, 32'd0);
        chk("reset alu misc", {11'd0, alu_funct, alu_alusrc, alu_imm_in2}, 32'd0);

        for (int k = 0; k < 10; k++) do_op(tbl[k], $sformatf("vec%0d", k));

        // Tie arbitration with both requesters streaming two ops each.
        do_reset();
        s0[0] = '{1'b0, FUNCT_SUB, 16'h0007, 16'h0007, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        s0[1] = '{1'b0, FUNCT_XOR, 16'h00FF, 16'h0F0F, 16'h0000, 1'b0, 16'h0FF0, 1'b0, 1'b0};
        s1[0] = '{1'b1, FUNCT_ADD, 16'h0001, 16'h0001, 16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0};
        s1[1] = '{1'b1, FUNCT_ADD, 16'h0010, 16'h0020, 16'h0000, 1'b0, 16'h0030, 1'b0, 1'b0};
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_order = '{1, 1, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        order = '{-1, -1, -1, -1};
        acc_cyc = '{0, 0, 0, 0};
        i0 = 0; i1 = 0; j0 = 0; j1 = 0; na = 0;
        for (int cyc = 0; cyc < 80 && !(j0 == 2 && j1 == 2); cyc++) begin
            @(negedge clk);
            drive(1'b0, i0 < 2, s0[i0 < 2 ? i0 : 1]);
            drive(1'b1, i1 < 2, s1[i1 < 2 ? i1 : 1]);
            #1;
            chk("tie single grant", {31'd0, r0_if.ready & r1_if.ready}, 32'd0);
            chk("tie rsp exclusive", {31'd0, r0_if.rsp_valid & r1_if.rsp_valid}, 32'd0);
            if (r0_if.ready && na < 4) begin
                order[na] = 0; acc_cyc[na] = cyc; na++; i0++;
            end else if (r1_if.ready && na < 4) begin
                order[na] = 1; acc_cyc[na] = cyc; na++; i1++;
            end
            if (r0_if.rsp_valid) begin
                if (j0 < 2) chk($sformatf("tie rsp0 %0d", j0), {15'd0, r0_if.rsp_zero, r0_if.rsp_result},
                                {15'd0, s0[j0].zero, s0[j0].res});
                else chk("tie extra rsp0", 32'd1, 32'd0);
                j0++;
            end
            if (r1_if.rsp_valid) begin
                if (j1 < 2) chk($sformatf("tie rsp1 %0d", j1), {15'd0, r1_if.rsp_zero, r1_if.rsp_result},
                                {15'd0, s1[j1].zero, s1[j1].res});
                else chk("tie extra rsp1", 32'd1, 32'd0);
                j1++;
            end
        end
        chk("tie done", {31'd0, (j0 == 2 && j1 == 2)}, 32'd1);
        for (int k = 0; k < 4; k++) chk($sformatf("tie order %0d", k), order[k], exp_order[k]);
        for (int k = 1; k < 4; k++) chk($sformatf("tie spacing %0d", k), acc_cyc[k] - acc_cyc[k-1], 4);

        // Immediate operand with response backpressure; req1 waits behind it.
        bp0 = '{1'b0, FUNCT_OR,  16'h00F0, 16'hFF00, 16'h000F, 1'b1, 16'h00FF, 1'b0, 1'b0};
        bp1 = '{1'b1, FUNCT_ADD, 16'h0002, 16'h0003, 16'h0000, 1'b0, 16'h0005, 1'b0, 1'b0};
        r0_if.rsp_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, bp0);
        wait_ready(1'b0, "bp req0");
        @(negedge clk);
        drive(1'b0, 1'b0, bp0);
        drive(1'b1, 1'b1, bp1);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bp req1 blocked issue/wait", {31'd0, r1_if.ready}, 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp rsp0 held", {13'd0, r0_if.rsp_valid, r0_if.rsp_zero, r0_if.rsp_overflow, r0_if.rsp_result},
                {13'd0, 1'b1, 1'b0, 1'b0, 16'h00FF});
            chk("bp req1 blocked resp", {31'd0, r1_if.ready}, 32'd0);
            @(negedge clk);
        end
        r0_if.rsp_ready = 1'b1;
        #1;
        chk("bp handshake cycle", {30'd0, r0_if.rsp_valid, r1_if.ready}, 32'd2);
        @(negedge clk);
        #1;
        chk("bp req1 granted", {30'd0, r0_if.rsp_valid, r1_if.ready}, 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, bp1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("bp req1 result", {15'd0, r1_if.rsp_valid, r1_if.rsp_result}, {15'd0, 1'b1, 16'h0005});
        @(negedge clk);

        // Reset while an op is in WAIT: the op is dropped with no response.
        drive(1'b0, 1'b1, tbl[4]);
        wait_ready(1'b0, "rst req0");
        @(negedge clk);
        drive(1'b0, 1'b0, tbl[4]);
        @(negedge clk);
        #1;
        chk("rst in wait state", {31'd0, alu_en | r0_if.rsp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst outputs ops", {alu_in1, alu_imm_in2}, 32'd0);
        chk("rst outputs misc", {27'd0, alu_en, alu_alusrc, r0_if.rsp_valid, r0_if.rsp_zero, r0_if.rsp_overflow}, 32'd0);
        chk("rst outputs result", {12'd0, alu_funct, r0_if.rsp_result}, 32'd0);
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (r0_if.rsp_valid) got = 1'b1;
        end
        chk("rst no response", {31'd0, got}, 32'd0);
        do_op(tbl[0], "post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
